// File: rtl/pulse_sync_toggle.sv
// Toggle-based pulse synchronizer: one-cycle events in clock_a become one-cycle
// pulses in clock_b through a toggle level, a flop chain and an edge detector.
module pulse_sync_toggle #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock_a,
    input  logic clock_b,
    input  logic async_rst_n,
    input  logic pls_a,
    output logic pls_b
);

    generate
        if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_cfg
            $error("pulse_sync_toggle: SYNC_STAGES must be in 2..4");
        end
    endgenerate

    logic                   tgl_a_d;
    logic                   tgl_a_q;
    logic [SYNC_STAGES-1:0] sync_d;
    (* ASYNC_REG = "TRUE" *)
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_d;
    logic                   prev_q;

    // Source-domain toggle: each sampled event flips the level once.
    always_comb begin
        tgl_a_d = tgl_a_q ^ pls_a;
    end

    // Source-domain toggle register.
    always_ff @(posedge clock_a or negedge async_rst_n) begin
        if (!async_rst_n) begin
            tgl_a_q <= 1'b0;
        end else begin
            tgl_a_q <= tgl_a_d;
        end
    end

    // Destination next-state: shift the toggle level in, remember the last synced value.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], tgl_a_q};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Destination synchronizer chain and edge-detect flop.
    always_ff @(posedge clock_b or negedge async_rst_n) begin
        if (!async_rst_n) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // Both XOR inputs are clock_b flops, so the pulse is glitch-free and one cycle wide.
    always_comb begin
        pls_b = sync_q[SYNC_STAGES-1] ^ prev_q;
    end

endmodule

// File: tb/tb_pulse_sync_toggle.sv
// Self-checking bench for pulse_sync_toggle: SYNC_STAGES=2 and 3 instances share
// stimulus; a queue-based event model checks pulse count, width and latency.
`timescale 1ns/1ps
module tb_pulse_sync_toggle;

    logic clock_a;
    logic clock_b;
    logic async_rst_n;
    logic pls_a;
    logic pls_b2;
    logic pls_b3;

    real  half_b = 3.5;
    int   n_chk  = 0;
    int   n_err  = 0;
    int   b_edges = 0;
    int   tot2 = 0;
    int   tot3 = 0;
    bit   last2 = 1'b0;
    bit   last3 = 1'b0;
    int   q2[$];
    int   q3[$];

    typedef struct {
        string tag;
        real   hb;
        int    n;
        int    hold;
        int    exp;
    } vec_t;
    vec_t tbl[6];
    real  hbs[5] = '{0.5, 1.5, 3.5, 6.5, 12.5};

    pulse_sync_toggle #(.SYNC_STAGES(2)) dut2 (
        .clock_a(clock_a), .clock_b(clock_b), .async_rst_n(async_rst_n),
        .pls_a(pls_a), .pls_b(pls_b2)
    );
    pulse_sync_toggle #(.SYNC_STAGES(3)) dut3 (
        .clock_a(clock_a), .clock_b(clock_b), .async_rst_n(async_rst_n),
        .pls_a(pls_a), .pls_b(pls_b3)
    );

    // clock_a edges land on whole ns; clock_b edges stay at x.25/x.75 ns so they never coincide
    initial begin
        clock_a = 1'b0;
        forever #5 clock_a = ~clock_a;
    end
    initial begin
        clock_b = 1'b0;
        #0.25;
        forever begin
            clock_b = ~clock_b;
            #(half_b);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    always @(posedge clock_b) b_edges++;

    // Reference model: every clock_a edge sampling pls_a=1 out of reset is one event.
    always @(posedge clock_a) begin
        if (async_rst_n === 1'b1 && pls_a === 1'b1) begin
            q2.push_back(b_edges);
            q3.push_back(b_edges);
        end
    end

    // Reset drops every in-flight event.
    always @(negedge async_rst_n) begin
        q2.delete();
        q3.delete();
    end

    // Output monitor, sampled on the falling clock_b edge.
    always @(negedge clock_b) begin
        if (async_rst_n !== 1'b1) begin
            check("rst_low_s2", int'(pls_b2), 0);
            check("rst_low_s3", int'(pls_b3), 0);
            last2 = 1'b0;
            last3 = 1'b0;
        end else begin
            if (pls_b2 === 1'b1) begin
                check("width_s2", int'(last2), 0);
                if (!last2) begin
                    tot2++;
                    check_rng("pending_s2", q2.size(), 1, 1000);
                    if (q2.size() > 0) check_rng("latency_s2", b_edges - q2.pop_front(), 2, 3);
                end
            end
            if (pls_b3 === 1'b1) begin
                check("width_s3", int'(last3), 0);
                if (!last3) begin
                    tot3++;
                    check_rng("pending_s3", q3.size(), 1, 1000);
                    if (q3.size() > 0) check_rng("latency_s3", b_edges - q3.pop_front(), 3, 4);
                end
            end
            last2 = pls_b2;
            last3 = pls_b3;
        end
    end

    // Issue n events (hold cycles each, 0 = random) at clock_b half period hb; exp<0 uses the issued count.
    task automatic run_events(input string tag, input real hb, input int n, input int hold,
                              input int jitter, input int exp_in);
        int gap;
        int h;
        int issued;
        int b2;
        int b3;
        half_b = hb;
        gap = int'($ceil(12.0 * hb / 10.0)) + 3;
        repeat (gap) @(negedge clock_a);
        b2 = tot2;
        b3 = tot3;
        issued = 0;
        for (int i = 0; i < n; i++) begin
            h = (hold > 0) ? hold : ((hb <= 0.5) ? int'($urandom_range(3, 1)) : 1);
            pls_a = 1'b1;
            repeat (h) @(negedge clock_a);
            pls_a = 1'b0;
            issued += h;
            repeat (gap + int'($urandom_range(jitter, 0))) @(negedge clock_a);
        end
        if (exp_in >= 0) begin
            check({tag, "_cnt_s2"}, tot2 - b2, exp_in);
            check({tag, "_cnt_s3"}, tot3 - b3, exp_in);
        end else begin
            check({tag, "_cnt_s2"}, tot2 - b2, issued);
            check({tag, "_cnt_s3"}, tot3 - b3, issued);
        end
        check({tag, "_drain_s2"}, q2.size(), 0);
        check({tag, "_drain_s3"}, q3.size(), 0);
    endtask

    initial begin
        int b2;
        int b3;
        tbl[0] = '{"single",     3.5,  1, 1, 1};
        tbl[1] = '{"five",       3.5,  5, 1, 5};
        tbl[2] = '{"held",       0.5,  1, 3, 3};
        tbl[3] = '{"b_fast",     1.5,  2, 1, 2};
        tbl[4] = '{"b_slow",     12.5, 2, 1, 2};
        tbl[5] = '{"b_vslow",    24.5, 1, 1, 1};

        // Reset only: pls_a unknown while reset is held.
        async_rst_n = 1'b0;
        pls_a = 1'bx;
        #2;
        check("rst_pls_b_s2", int'(pls_b2), 0);
        check("rst_pls_b_s3", int'(pls_b3), 0);
        #8;
        async_rst_n = 1'b1;
        pls_a = 1'b0;
        repeat (20) @(negedge clock_a);
        check("idle_cnt_s2", tot2, 0);
        check("idle_cnt_s3", tot3, 0);

        for (int i = 0; i < 6; i++) begin
            run_events(tbl[i].tag, tbl[i].hb, tbl[i].n, tbl[i].hold, 0, tbl[i].exp);
        end

        // Reset while an event is in flight: dropped, then a fresh event gets through.
        half_b = 3.5;
        repeat (5) @(negedge clock_a);
        b2 = tot2;
        b3 = tot3;
        pls_a = 1'b1;
        @(posedge clock_a);
        #1;
        pls_a = 1'b0;
        async_rst_n = 1'b0;
        #0.1;
        check("mid_tgl_s2", int'(dut2.tgl_a_q), 0);
        check("mid_tgl_s3", int'(dut3.tgl_a_q), 0);
        check("mid_sync_s2", int'(dut2.sync_q), 0);
        check("mid_sync_s3", int'(dut3.sync_q), 0);
        check("mid_pls_s2", int'(pls_b2), 0);
        check("mid_pls_s3", int'(pls_b3), 0);
        #20;
        @(negedge clock_a);
        async_rst_n = 1'b1;
        repeat (15) @(negedge clock_a);
        check("mid_drop_s2", tot2 - b2, 0);
        check("mid_drop_s3", tot3 - b3, 0);
        run_events("post_rst", 3.5, 1, 1, 0, 1);

        // Randomized clock ratios, event counts and spacing.
        for (int r = 0; r < 8; r++) begin
            run_events("rand", hbs[$urandom_range(4, 0)], int'($urandom_range(4, 1)), 0, 4, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
